stream_demux_router: RTL

- Other end of the QoS stream arbiter: takes the single arbitrated stream (data, qos, id, last) and routes whole packets back out to STREAM_COUNT output streams, selected by id.
- Destination is locked per packet on the first beat. Packets with an out-of-range id are accepted and discarded.
- One registered output stage: latency 1, full throughput under continuous ready.

---
 rtl/stream_demux_router.sv | 73 +++++++
 1 files changed

// File: rtl/stream_demux_router.sv
// stream_demux_router: routes whole packets from one stream to STREAM_COUNT outputs by id, discarding out-of-range ids
module stream_demux_router #(
  parameter int T_DATA_WIDTH   = 8,
  parameter int T_QOS__WIDTH   = 4,
  parameter int STREAM_COUNT   = 2,
  parameter int T_ID___WIDTH   = $clog2(STREAM_COUNT),
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [T_DATA_WIDTH-1:0]                    s_data_i,
  input  logic [T_QOS__WIDTH-1:0]                    s_qos_i,
  input  logic [T_ID___WIDTH-1:0]                    s_id_i,
  input  logic                                       s_last_i,
  input  logic                                       s_valid_i,
  output logic                                       s_ready_o,
  output logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0]  m_data_o,
  output logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0]  m_qos_o,
  output logic [STREAM_COUNT-1:0]                    m_last_o,
  output logic [STREAM_COUNT-1:0]                    m_valid_o,
  input  logic [STREAM_COUNT-1:0]                    m_ready_i,
  output logic [DROP_CNT_WIDTH-1:0]                  drop_cnt_o
);
  typedef enum logic [1:0] {HEAD, BODY, DROP} state_t;
  localparam logic [T_ID___WIDTH:0] ID_LIMIT = (T_ID___WIDTH+1)'(STREAM_COUNT);
  state_t                    state;
  logic [T_ID___WIDTH-1:0]   lock_id, out_dest, cur_dest;
  logic                      out_valid, out_last, head_drop, discard, out_hs, accept;
  logic [T_DATA_WIDTH-1:0]   out_data;
  logic [T_QOS__WIDTH-1:0]   out_qos;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;
  // m_valid_o is one-hot at out_dest, so any handshake means the held beat's port is ready
  always_comb begin
    cur_dest  = state == BODY ? lock_id : s_id_i;
    head_drop = state == HEAD && {1'b0, s_id_i} >= ID_LIMIT;
    discard   = head_drop || state == DROP;
    out_hs    = |(m_valid_o & m_ready_i);
    s_ready_o = discard || !out_valid || out_hs;
    accept    = s_valid_i && s_ready_o;
  end
  for (genvar k = 0; k < STREAM_COUNT; k++) begin : g_out
    assign m_valid_o[k] = out_valid && out_dest == T_ID___WIDTH'(k);
    assign m_last_o[k]  = out_last && m_valid_o[k];
    assign m_data_o[k]  = out_data;
    assign m_qos_o[k]   = out_qos;
  end
  assign drop_cnt_o = drop_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= HEAD;
      lock_id   <= '0;
      out_valid <= 1'b0;
      out_dest  <= '0;
      out_data  <= '0;
      out_qos   <= '0;
      out_last  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (accept && !discard) begin
        out_valid <= 1'b1;
        out_dest  <= cur_dest;
        out_data  <= s_data_i;
        out_qos   <= s_qos_i;
        out_last  <= s_last_i;
      end else if (out_hs) out_valid <= 1'b0;
      if (accept && state == HEAD) begin
        state <= s_last_i ? HEAD : (head_drop ? DROP : BODY);
        if (!s_last_i && !head_drop) lock_id <= s_id_i;
        if (head_drop && !(&drop_cnt)) drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
      end else if (accept && s_last_i) state <= HEAD;
    end
  end
endmodule
